// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Two-requester controller for a single-port, byte-wide data memory. Port A
//   (pipeline MEM stage) and port B (debug/DMA loader) issue doubleword
//   requests; the winner of a round-robin arbitration is sequenced as
//   WORD_BYTES byte beats on the memory interface, then acknowledged.
//
//   Optional build macro: DMEM_ALIGN_CHECK_EN -- when defined, a granted
//   address that is not WORD_BYTES-aligned is rejected with err like an
//   out-of-range address.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  port A request (held until a_ack)
//   a_ack/a_err/a_rdata        port A completion pulse, error, read data
//   b_*                        same as port A, for port B
//   mem_addr/mem_re/mem_we/mem_wdata  byte strobes to the array
//   mem_rdata             combinational read byte for mem_addr
//   busy, owner           transfer in progress, current owner (0=A, 1=B)
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int MEM_BYTES  = 64,
  parameter int WORD_BYTES = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         a_req,
  input  logic                         a_we,
  input  logic [ADDR_W-1:0]            a_addr,
  input  logic [8*WORD_BYTES-1:0]      a_wdata,
  output logic                         a_ack,
  output logic                         a_err,
  output logic [8*WORD_BYTES-1:0]      a_rdata,
  input  logic                         b_req,
  input  logic                         b_we,
  input  logic [ADDR_W-1:0]            b_addr,
  input  logic [8*WORD_BYTES-1:0]      b_wdata,
  output logic                         b_ack,
  output logic                         b_err,
  output logic [8*WORD_BYTES-1:0]      b_rdata,
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
  output logic                         mem_re,
  output logic                         mem_we,
  output logic [7:0]                   mem_wdata,
  input  logic [7:0]                   mem_rdata,
  output logic                         busy,
  output logic                         owner
);

  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam int BW     = $clog2(WORD_BYTES);
  localparam int DW     = 8 * WORD_BYTES;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [BW-1:0]   BEAT_ZERO = BW'(0);
  localparam logic [BW-1:0]   BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0]   BEAT_LAST = BW'(WORD_BYTES - 1);
  localparam logic [ADDR_W:0] WORD_SPAN = (ADDR_W + 1)'(WORD_BYTES);
  localparam logic [ADDR_W:0] MEM_SPAN  = (ADDR_W + 1)'(MEM_BYTES);

  logic [1:0]        state_q,      state_d;
  logic [BW-1:0]     beat_q,       beat_d;
  logic              owner_q,      owner_d;
  logic              we_q,         we_d;
  logic [MEM_AW-1:0] addr_q,       addr_d;
  logic [DW-1:0]     wdata_q,      wdata_d;
  logic [DW-1:0]     rbuf_q,       rbuf_d;
  logic              last_grant_q, last_grant_d;
  logic              a_ack_q,      a_ack_d;
  logic              a_err_q,      a_err_d;
  logic [DW-1:0]     a_rdata_q,    a_rdata_d;
  logic              b_ack_q,      b_ack_d;
  logic              b_err_q,      b_err_d;
  logic [DW-1:0]     b_rdata_q,    b_rdata_d;
  logic [MEM_AW-1:0] mem_addr_q,   mem_addr_d;
  logic              mem_re_q,     mem_re_d;
  logic              mem_we_q,     mem_we_d;
  logic [7:0]        mem_wdata_q,  mem_wdata_d;
  logic              busy_q,       busy_d;

  logic              grant_b_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DW-1:0]     sel_wdata_s;
  logic [ADDR_W:0]   sel_end_s;
  logic              range_err_s;
  logic              align_err_s;

  // Arbitration and range check for the request seen in IDLE.
  always_comb begin
    // B wins when alone, or on a tie when A held the previous grant.
    grant_b_s = b_req & (~a_req | ~last_grant_q);
    if (grant_b_s) begin
      sel_we_s    = b_we;
      sel_addr_s  = b_addr;
      sel_wdata_s = b_wdata;
    end else begin
      sel_we_s    = a_we;
      sel_addr_s  = a_addr;
      sel_wdata_s = a_wdata;
    end
    // One extra bit so addresses near the top of the space cannot wrap.
    sel_end_s   = {1'b0, sel_addr_s} + WORD_SPAN;
    range_err_s = (sel_end_s > MEM_SPAN);
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err_s = |sel_addr_s[BW-1:0];
`else
  assign align_err_s = 1'b0;
`endif

  // Next-state logic for the IDLE -> XFER -> DONE sequencer and its outputs.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    last_grant_d = last_grant_q;
    a_ack_d      = 1'b0;
    a_err_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_ack_d      = 1'b0;
    b_err_d      = 1'b0;
    b_rdata_d    = b_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    busy_d       = busy_q;

    case (state_q)
      S_IDLE: begin
        if (a_req | b_req) begin
          owner_d = grant_b_s;
          we_d    = sel_we_s;
          addr_d  = sel_addr_s[MEM_AW-1:0];
          wdata_d = sel_wdata_s;
          busy_d  = 1'b1;
          if (range_err_s | align_err_s) begin
            // Rejected: acknowledge next cycle without touching the array.
            state_d = S_DONE;
            a_ack_d = ~grant_b_s;
            a_err_d = ~grant_b_s;
            b_ack_d = grant_b_s;
            b_err_d = grant_b_s;
          end else begin
            // Beat 0 strobes are registered here so they appear at T+1.
            state_d     = S_XFER;
            beat_d      = BEAT_ZERO;
            mem_addr_d  = sel_addr_s[MEM_AW-1:0];
            mem_re_d    = ~sel_we_s;
            mem_we_d    = sel_we_s;
            mem_wdata_d = sel_wdata_s[7:0];
          end
        end else begin
          busy_d = 1'b0;
        end
      end

      S_XFER: begin
        if (~we_q) begin
          rbuf_d[{beat_q, 3'b000} +: 8] = mem_rdata;
        end else begin
          rbuf_d = rbuf_q;
        end
        if (beat_q == BEAT_LAST) begin
          state_d = S_DONE;
          a_ack_d = ~owner_q;
          b_ack_d = owner_q;
          // Only a completed read replaces the owner's visible read data.
          if (~we_q & owner_q) begin
            b_rdata_d = rbuf_d;
          end else if (~we_q) begin
            a_rdata_d = rbuf_d;
          end else begin
            a_rdata_d = a_rdata_q;
          end
        end else begin
          beat_d      = beat_q + BEAT_ONE;
          mem_addr_d  = addr_q + MEM_AW'(beat_d);
          mem_re_d    = ~we_q;
          mem_we_d    = we_q;
          mem_wdata_d = wdata_q[{beat_d, 3'b000} +: 8];
        end
      end

      S_DONE: begin
        state_d      = S_IDLE;
        busy_d       = 1'b0;
        last_grant_d = owner_q;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything and favours A next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      beat_q       <= BEAT_ZERO;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      last_grant_q <= 1'b1;
      a_ack_q      <= 1'b0;
      a_err_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_ack_q      <= 1'b0;
      b_err_q      <= 1'b0;
      b_rdata_q    <= '0;
      mem_addr_q   <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      last_grant_q <= last_grant_d;
      a_ack_q      <= a_ack_d;
      a_err_q      <= a_err_d;
      a_rdata_q    <= a_rdata_d;
      b_ack_q      <= b_ack_d;
      b_err_q      <= b_err_d;
      b_rdata_q    <= b_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign a_err     = a_err_q;
  assign a_rdata   = a_rdata_q;
  assign b_ack     = b_ack_q;
  assign b_err     = b_err_q;
  assign b_rdata   = b_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [63:0] a_rdata, b_rdata;
  logic [5:0]  mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy, owner;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic load_en;

  logic [7:0] mem  [0:63];
  logic [7:0] gmem [0:63];
  logic [7:0] saved [0:63];

  typedef struct {
    logic        port;
    logic        we;
    logic        err;
    logic [63:0] rdata;
    int          ack_cyc;
  } ack_t;

  typedef struct {
    logic       owner;
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
  } beat_t;

  ack_t  ack_q  [$];
  beat_t beat_q [$];
  logic [63:0] exp_a_rdata, exp_b_rdata;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide array: preload byte i = i, otherwise write on strobe.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare strobes and acks of this cycle against the scoreboard.
  task automatic monitor_step();
    ack_t  e;
    beat_t bt;
    if (mem_re || mem_we) begin
      chk("strobe_exclusive", 64'(mem_re & mem_we), 64'd0);
      chk("beat_pending", 64'(beat_q.size() != 0), 64'd1);
      if (beat_q.size() != 0) begin
        bt = beat_q.pop_front();
        chk("beat_addr", 64'(mem_addr), 64'(bt.addr));
        chk("beat_we", 64'(mem_we), 64'(bt.we));
        chk("beat_busy_owner", {62'd0, busy, owner}, {62'd0, 1'b1, bt.owner});
        if (bt.we) chk("beat_wdata", 64'(mem_wdata), 64'(bt.data));
      end
    end
    if (a_ack || b_ack) begin
      chk("ack_single", 64'(a_ack & b_ack), 64'd0);
      chk("ack_pending", 64'(ack_q.size() != 0), 64'd1);
      if (ack_q.size() != 0) begin
        e = ack_q.pop_front();
        chk("ack_port", 64'(b_ack), 64'(e.port));
        chk("ack_err", 64'(e.port ? b_err : a_err), 64'(e.err));
        chk("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
        if (!e.we && !e.err) begin
          if (e.port) exp_b_rdata = e.rdata;
          else        exp_a_rdata = e.rdata;
        end
        chk("a_rdata", a_rdata, exp_a_rdata);
        chk("b_rdata", b_rdata, exp_b_rdata);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_step();
  endtask

  task automatic issue(input logic port, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata);
    if (port) begin
      b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
    end else begin
      a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
    end
  endtask

  // Push expected beats and ack; golden memory follows service order.
  task automatic expect_txn(input logic port, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input int ack_cyc);
    ack_t        e;
    beat_t       bt;
    logic [64:0] end_a;
    logic [63:0] wd;
    end_a = {1'b0, addr} + 65'd8;
    e.err = (end_a > 65'd64);
`ifdef DMEM_ALIGN_CHECK_EN
    if (addr[2:0] != 3'd0) e.err = 1'b1;
`endif
    e.port = port; e.we = we; e.rdata = 64'd0; e.ack_cyc = ack_cyc;
    wd = wdata;
    if (!e.err) begin
      for (int k = 0; k < 8; k++) begin
        bt.owner = port;
        bt.we    = we;
        bt.addr  = addr[5:0] + 6'(k);
        bt.data  = wd[8*k +: 8];
        beat_q.push_back(bt);
        if (we) gmem[bt.addr] = wd[8*k +: 8];
        else    e.rdata[8*k +: 8] = gmem[bt.addr];
      end
    end
    ack_q.push_back(e);
  endtask

  task automatic wait_ack(input logic port);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (port ? b_ack : a_ack) begin
        seen = 1'b1;
        if (port) b_req = 1'b0;
        else      a_req = 1'b0;
      end
    end
    chk(port ? "b_ack_timeout" : "a_ack_timeout", 64'(seen), 64'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_acks"}, {60'd0, a_ack, a_err, b_ack, b_err}, 64'd0);
    chk({tag, "_a_rdata"}, a_rdata, 64'd0);
    chk({tag, "_b_rdata"}, b_rdata, 64'd0);
    chk({tag, "_strobes"}, {62'd0, mem_re, mem_we}, 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_busy_owner"}, {62'd0, busy, owner}, 64'd0);
  endtask

  initial begin
    int t0;
    logic [63:0] wd;
    reset = 1'b1; load_en = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 64'd0; a_wdata = 64'd0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 64'd0; b_wdata = 64'd0;
    exp_a_rdata = 64'd0; exp_b_rdata = 64'd0;
    for (int i = 0; i < 64; i++) gmem[i] = 8'(i);
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    load_en = 1'b0;
    reset = 1'b0;

    // A read addr 0
    tick(); issue(1'b0, 1'b0, 64'd0, 64'd0); t0 = cyc;
    expect_txn(1'b0, 1'b0, 64'd0, 64'd0, t0 + 9);
    wait_ack(1'b0);
    chk("a_read0_value", a_rdata, 64'h0706050403020100);

    // B write addr 16; data/addr inputs scribbled after latching
    tick(); issue(1'b1, 1'b1, 64'd16, 64'hDEADBEEFCAFEF00D); t0 = cyc;
    expect_txn(1'b1, 1'b1, 64'd16, 64'hDEADBEEFCAFEF00D, t0 + 9);
    tick(); b_addr = 64'd0; b_wdata = 64'd0;
    wait_ack(1'b1);

    // B read addr 16
    tick(); issue(1'b1, 1'b0, 64'd16, 64'd0); t0 = cyc;
    expect_txn(1'b1, 1'b0, 64'd16, 64'd0, t0 + 9);
    wait_ack(1'b1);
    chk("b_read16_value", b_rdata, 64'hDEADBEEFCAFEF00D);

    // Tie after reset-default last grant: A first, then B
    tick(); issue(1'b0, 1'b0, 64'd8, 64'd0); issue(1'b1, 1'b0, 64'd24, 64'd0); t0 = cyc;
    expect_txn(1'b0, 1'b0, 64'd8, 64'd0, t0 + 9);
    expect_txn(1'b1, 1'b0, 64'd24, 64'd0, t0 + 19);
    wait_ack(1'b0);
    wait_ack(1'b1);

    // Range boundary cases
    tick(); issue(1'b0, 1'b0, 64'd56, 64'd0); t0 = cyc;
    expect_txn(1'b0, 1'b0, 64'd56, 64'd0, t0 + 9);
    wait_ack(1'b0);
    chk("a_read56_value", a_rdata, 64'h3F3E3D3C3B3A3938);
    tick(); issue(1'b0, 1'b0, 64'd57, 64'd0); t0 = cyc;
    expect_txn(1'b0, 1'b0, 64'd57, 64'd0, t0 + 1);
    wait_ack(1'b0);
    tick(); issue(1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0); t0 = cyc;
    expect_txn(1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, t0 + 1);
    wait_ack(1'b0);
    tick(); issue(1'b1, 1'b1, 64'd60, 64'h1111111111111111); t0 = cyc;
    expect_txn(1'b1, 1'b1, 64'd60, 64'h1111111111111111, t0 + 1);
    wait_ack(1'b1);

    // Unaligned read addr 4 (error only with the alignment check built in)
    tick(); issue(1'b0, 1'b0, 64'd4, 64'd0); t0 = cyc;
`ifdef DMEM_ALIGN_CHECK_EN
    expect_txn(1'b0, 1'b0, 64'd4, 64'd0, t0 + 1);
`else
    expect_txn(1'b0, 1'b0, 64'd4, 64'd0, t0 + 9);
`endif
    wait_ack(1'b0);

    // Lone A, then a tie: B must win now
    tick(); issue(1'b0, 1'b0, 64'd32, 64'd0); t0 = cyc;
    expect_txn(1'b0, 1'b0, 64'd32, 64'd0, t0 + 9);
    wait_ack(1'b0);
    tick(); issue(1'b0, 1'b0, 64'd40, 64'd0); issue(1'b1, 1'b0, 64'd48, 64'd0); t0 = cyc;
    expect_txn(1'b1, 1'b0, 64'd48, 64'd0, t0 + 9);
    expect_txn(1'b0, 1'b0, 64'd40, 64'd0, t0 + 19);
    wait_ack(1'b1);
    wait_ack(1'b0);

    // A write addr 8 interrupted by reset during beat 3
    wd = 64'h1122334455667788;
    saved = gmem;
    tick(); issue(1'b0, 1'b1, 64'd8, wd); t0 = cyc;
    expect_txn(1'b0, 1'b1, 64'd8, wd, t0 + 9);
    repeat (3) tick();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    ack_q.delete();
    beat_q.delete();
    a_req = 1'b0;
    exp_a_rdata = 64'd0; exp_b_rdata = 64'd0;
    gmem = saved;
    for (int k = 0; k < 3; k++) gmem[8 + k] = wd[8*k +: 8];
    tick();
    for (int k = 0; k < 8; k++) chk("mem_after_reset", 64'(mem[8 + k]), 64'(gmem[8 + k]));
    tick();
    chk("ack_after_reset", {62'd0, a_ack, b_ack}, 64'd0);
    reset = 1'b0;

    // Tie after release goes to A
    issue(1'b0, 1'b0, 64'd0, 64'd0); issue(1'b1, 1'b0, 64'd8, 64'd0); t0 = cyc;
    expect_txn(1'b0, 1'b0, 64'd0, 64'd0, t0 + 9);
    expect_txn(1'b1, 1'b0, 64'd8, 64'd0, t0 + 19);
    wait_ack(1'b0);
    wait_ack(1'b1);
    chk("b_read8_partial", b_rdata, 64'h0F0E0D0C0B667788);

    repeat (3) tick();
    chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
    chk("beat_queue_drained", 64'(beat_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Two-requester controller for the byte-organised data memory (64 bytes, little-endian doubleword access).
- Arbitrates between port A (pipeline MEM stage) and port B (debug/DMA loader), then sequences each 64-bit access as eight byte beats on a single-port, byte-wide memory interface.
- Sits between the requesters and the memory array; it is the only master of the array.

Parameters:
- ADDR_W, 64, requester address width.
- MEM_BYTES, 64, memory size in bytes; must be a power of two.
- WORD_BYTES, 8, bytes per access; beat count per transfer.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  port A request; held until a_ack
- a_we  in  1  port A 1=write, 0=read
- a_addr  in  ADDR_W  port A byte address of byte 0
- a_wdata  in  64  port A write data, byte 0 in [7:0]
- a_ack  out  1  one-cycle completion pulse
- a_err  out  1  valid with a_ack; range error, no access performed
- a_rdata  out  64  read data; valid with a_ack, held until next port A ack
- b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata  same as port A, for port B
- mem_addr  out  log2(MEM_BYTES)  byte address to array
- mem_re  out  1  read strobe
- mem_we  out  1  write strobe, array writes on rising clk
- mem_wdata  out  8  write byte
- mem_rdata  in  8  combinational read byte for mem_addr
- busy  out  1  transfer in progress
- owner  out  1  0=A, 1=B; meaningful while busy

Behaviour:
- Reset (async, active-high): state IDLE, beat=0, all acks/errs/strobes/busy/owner=0, mem_addr=0, mem_wdata=0, rdata regs=0, last_grant=B, so A wins the first tie.
- FSM IDLE -> XFER -> DONE -> IDLE.
- IDLE:
  - Sample requests. Only one requesting: grant it. Both requesting: grant the port not equal to last_grant (round robin).
  - Latch owner, we, addr, wdata.
  - Range check on grant: addr + WORD_BYTES > MEM_BYTES, computed ADDR_W+1 bits wide (no wrap), is an error. Error -> DONE directly, no strobes, err=1.
  - Otherwise -> XFER with beat=0.
- XFER, beat k = 0..WORD_BYTES-1:
  - mem_addr = addr[low bits] + k. Read: mem_re=1. Write: mem_we=1 and mem_wdata = wdata byte k.
  - Read captures mem_rdata into rdata byte lane k at the clock edge.
  - After the last beat -> DONE.
- DONE: owner's ack=1 for one cycle, err as determined; last_grant=owner. Rdata register updates only on a successful read. Then -> IDLE.
- Latency with no contention: req seen in IDLE cycle T; beats T+1..T+8; ack at T+9. Error ack at T+1.
- Requester drops req in the cycle after ack. A req still high in IDLE is a new request.
- Loser of arbitration waits, req held; it is served next. Back-to-back ties alternate A,B,A,B.
- Inputs of the owning port are ignored after latching. The other port's req is ignored while busy.
- Strobes are never active in IDLE or DONE. mem_re and mem_we are never both high.
- busy=1 in XFER and DONE.
- Reset mid-transfer: immediate return to IDLE, no ack. Bytes already written remain written. Partial read data is discarded (rdata regs cleared).

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: a granted address with addr[2:0] != 0 is also an error (err=1, no access, ack at T+1).
- Undefined: any in-range byte address is legal; unaligned accesses perform eight consecutive byte beats.

Test Plan:
- Memory model preloaded byte i = i. A read at addr 0 -> a_ack at T+9, a_rdata=0x0706050403020100, a_err=0, eight mem_re beats at addresses 0..7.
- B write addr 16, wdata 0xDEADBEEFCAFEF00D -> mem_we beats at 16..23 with bytes 0D,F0,FE,CA,EF,BE,AD,DE. Then B read addr 16 returns 0xDEADBEEFCAFEF00D.
- A and B request in the same cycle, both held -> A served first (ack T+9), B granted in the following IDLE. A second simultaneous pair -> B served first.
- A read addr 57 -> a_ack at T+1 with a_err=1, no strobes. Addr 56 -> ok, bytes 56..63. Addr 0xFFFFFFFFFFFFFFFC -> err (no wrap).
- Reset asserted during beat 3 of a write to addr 8 -> all outputs 0 immediately, no ack, bytes 8..10 updated and 11..15 unchanged. After release, a tie goes to A.
- With DMEM_ALIGN_CHECK_EN, read addr 4 -> err at T+1. Without it, read addr 4 -> 0x0B0A090807060504.
